// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - loader state encoding and load-stream format constants
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WORD_HI,
    ST_WORD_LO,
    ST_DONE
  } loader_state_t;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 2;

  // True when the 16-bit stream word carries bits the instruction width cannot hold
  function automatic logic hi_bits_set(input logic [15:0] word, input int w);
    return (word >> w) != 16'd0;
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - load byte stream in, instruction-memory write port out
interface inst_loader_if #(
  parameter int A = 16,
  parameter int W = 9
);
  logic         InValid;
  logic [7:0]   InByte;
  logic         InReady;
  logic         WrEn;
  logic [A-1:0] WrAddr;
  logic [W-1:0] WrData;

  modport master (
    output InValid,
    output InByte,
    input  InReady,
    input  WrEn,
    input  WrAddr,
    input  WrData
  );

  modport slave (
    input  InValid,
    input  InByte,
    output InReady,
    output WrEn,
    output WrAddr,
    output WrData
  );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - parses a length-prefixed byte stream into instruction-memory writes
module inst_loader
  import loader_pkg::*;
#(
  parameter int A = 16,
  parameter int W = 9
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  inst_loader_if.slave  bus,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic [7:0]   r_len_hi;
  logic [7:0]   r_word_hi;
  logic [15:0]  r_remaining;
  logic [A-1:0] r_next_addr;
  logic         r_wr_en;
  logic [A-1:0] r_wr_addr;
  logic [W-1:0] r_wr_data;
  logic         r_err;

  logic         w_busy;
  logic         w_xfer;
  logic         w_start;
  logic [15:0]  w_len;
  logic [15:0]  w_word;

  assign w_busy  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                   (r_state == ST_WORD_HI) || (r_state == ST_WORD_LO);
  assign w_xfer  = bus.InValid && w_busy;
  assign w_start = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_len   = {r_len_hi, bus.InByte};
  assign w_word  = {r_word_hi, bus.InByte};

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) w_state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer) w_state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_xfer) w_state_nxt = (w_len != 16'd0) ? ST_WORD_HI : ST_DONE;
      end
      ST_WORD_HI: begin
        if (w_xfer) w_state_nxt = ST_WORD_LO;
      end
      ST_WORD_LO: begin
        if (w_xfer) w_state_nxt = (r_remaining == 16'd1) ? ST_DONE : ST_WORD_HI;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write port only moves on a WORD_LO transfer, so address/data hold between strobes
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_len_hi    <= '0;
      r_word_hi   <= '0;
      r_remaining <= '0;
      r_next_addr <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_next_addr <= '0;
        r_err       <= 1'b0;
      end
      if (w_xfer) begin
        unique case (r_state)
          ST_LEN_HI:  r_len_hi  <= bus.InByte;
          ST_LEN_LO:  r_remaining <= w_len;
          ST_WORD_HI: r_word_hi <= bus.InByte;
          ST_WORD_LO: begin
            r_wr_en     <= 1'b1;
            r_wr_addr   <= r_next_addr;
            r_wr_data   <= w_word[W-1:0];
            r_next_addr <= r_next_addr + 1'b1;
            r_remaining <= r_remaining - 16'd1;
            if (hi_bits_set(w_word, W)) r_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.InReady = w_busy;
  assign bus.WrEn    = r_wr_en;
  assign bus.WrAddr  = r_wr_addr;
  assign bus.WrData  = r_wr_data;
  assign Busy        = w_busy;
  assign Done        = (r_state == ST_DONE);
  assign Err         = r_err;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench, full-width and 2-bit-address loaders driven in lockstep
module tb_inst_loader;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Start = 1'b0;
  logic Busy0, Done0, Err0;
  logic Busy1, Done1, Err1;

  inst_loader_if #(.A(16), .W(9)) bus0 ();
  inst_loader_if #(.A(2),  .W(9)) bus1 ();

  inst_loader #(.A(16), .W(9)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .bus(bus0),
    .Busy(Busy0), .Done(Done0), .Err(Err0)
  );

  inst_loader #(.A(2), .W(9)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .bus(bus1),
    .Busy(Busy1), .Done(Done1), .Err(Err1)
  );

  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_addr = 0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (bus0.WrEn === 1'b1) begin
      if (q0.size() == 0) chk("wr0_unexpected", 32'd1, 32'd0);
      else chk("wr0", {16'(bus0.WrAddr), 16'(bus0.WrData)}, q0.pop_front());
    end
    if (bus1.WrEn === 1'b1) begin
      if (q1.size() == 0) chk("wr1_unexpected", 32'd1, 32'd0);
      else chk("wr1", {16'(bus1.WrAddr), 16'(bus1.WrData)}, q1.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [7:0] b);
    bus0.InValid = v;
    bus1.InValid = v;
    bus0.InByte  = b;
    bus1.InByte  = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall, input bit poke);
    int gaps;
    int t;
    gaps = stall ? int'($urandom_range(0, 3)) : 0;
    if (poke) begin
      drive(1'b0, 8'h00);
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    for (int i = 0; i < gaps; i++) begin
      drive(1'b0, 8'h00);
      @(posedge Clk); #1;
    end
    drive(1'b1, b);
    t = 0;
    while (bus0.InReady !== 1'b1 && t < 50) begin
      @(posedge Clk); #1;
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge Clk); #1;
    drive(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input bit stall, input bit poke);
    logic [15:0] word;
    word = {hi, lo};
    q0.push_back({16'(m_addr % 65536), word & 16'h01FF});
    q1.push_back({16'(m_addr % 4),     word & 16'h01FF});
    m_addr++;
    if ((word >> 9) != 16'd0) m_err = 1'b1;
    send_byte(hi, stall, poke);
    send_byte(lo, stall, poke);
  endtask

  task automatic start_load();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    m_addr = 0;
    m_err  = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (3) @(posedge Clk);
    #1;
    chk({tag, "_q0_left"}, q0.size(), 32'd0);
    chk({tag, "_q1_left"}, q1.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 8'h00);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_inready", bus0.InReady, 32'd0);
    chk("rst_wren",    bus0.WrEn,    32'd0);
    chk("rst_wraddr",  bus0.WrAddr,  32'd0);
    chk("rst_wrdata",  bus0.WrData,  32'd0);
    chk("rst_busy",    Busy0,        32'd0);
    chk("rst_done",    Done0,        32'd0);
    chk("rst_err",     Err0,         32'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // two words, no stalls
    start_load();
    chk("t1_busy", Busy0, 32'd1);
    chk("t1_ready", bus0.InReady, 32'd1);
    send_byte(8'h00, 0, 0);
    send_byte(8'h02, 0, 0);
    send_word(8'h01, 8'h23, 0, 0);
    send_word(8'h00, 8'h45, 0, 0);
    settle("t1");
    chk("t1_done", Done0, 32'd1);
    chk("t1_err",  Err0,  32'd0);
    chk("t1_busy_end", Busy0, 32'd0);

    // empty load
    start_load();
    chk("t2_done_cleared", Done0, 32'd0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0);
    chk("t2_done", Done0, 32'd1);
    settle("t2");

    // oversize word sets Err, next Start clears it
    start_load();
    send_byte(8'h00, 0, 0);
    send_byte(8'h01, 0, 0);
    send_word(8'hFE, 8'h01, 0, 0);
    settle("t3");
    chk("t3_err", Err0, 32'd1);
    chk("t3_done", Done0, 32'd1);
    start_load();
    chk("t3_err_cleared", Err0, 32'd0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0);
    settle("t3b");

    // stalls and ignored Start pulses mid-load
    start_load();
    send_byte(8'h00, 1, 1);
    send_byte(8'h03, 1, 1);
    for (int i = 0; i < 3; i++)
      send_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, 1);
    settle("t4");
    chk("t4_done", Done0, 32'd1);
    chk("t4_err",  Err0,  32'(m_err));

    // reset mid-load, then restart from address 0
    start_load();
    send_byte(8'h00, 0, 0);
    send_byte(8'h03, 0, 0);
    send_word(8'h01, 8'h23, 0, 0);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    chk("t5_inready", bus0.InReady, 32'd0);
    chk("t5_wren",    bus0.WrEn,    32'd0);
    chk("t5_wraddr",  bus0.WrAddr,  32'd0);
    chk("t5_wrdata",  bus0.WrData,  32'd0);
    chk("t5_busy",    Busy0,        32'd0);
    chk("t5_done",    Done0,        32'd0);
    chk("t5_err",     Err0,         32'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    start_load();
    send_byte(8'h00, 0, 0);
    send_byte(8'h01, 0, 0);
    send_word(8'h00, 8'h77, 0, 0);
    settle("t5");
    chk("t5_done_end", Done0, 32'd1);

    // five words into a 4-entry address space wraps to 0
    start_load();
    send_byte(8'h00, 0, 0);
    send_byte(8'h05, 0, 0);
    for (int i = 0; i < 5; i++)
      send_word(8'h01, 8'(i * 16 + 3), 0, 0);
    settle("t6");
    chk("t6_done_a2", Done1, 32'd1);
    chk("t6_done_a16", Done0, 32'd1);
    chk("t6_err_a2", Err1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter A, default 16, meaning the instruction address width.
REQ-002 SHALL have parameter W, default 9, meaning the instruction width; W <= 16.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port Start, input, 1, a one-cycle request to begin a load.
REQ-006 SHALL have port InValid, input, 1, meaning InByte is valid this cycle.
REQ-007 SHALL have port InByte, input, 8, the load-stream byte.
REQ-008 SHALL have port InReady, output, 1, meaning the loader accepts a byte this cycle.
REQ-009 SHALL have port WrEn, output, 1, the instruction-memory write strobe.
REQ-010 SHALL have port WrAddr, output, A, the instruction-memory write address.
REQ-011 SHALL have port WrData, output, W, the instruction-memory write data.
REQ-012 SHALL have port Busy, output, 1, high while a load is in progress.
REQ-013 SHALL have port Done, output, 1, a level meaning the load is complete and the processor may fetch.
REQ-014 SHALL have port Err, output, 1, sticky per load, meaning a word had nonzero bits above W.

Function
REQ-015 SHALL transfer a byte only when InValid and InReady are both high on the same edge.
REQ-016 SHALL accept the stream format: count high byte, count low byte (16-bit N), then N words of 2 bytes each, high byte first.
REQ-017 SHALL implement states IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO and DONE.
REQ-018 SHALL transition IDLE or DONE to LEN_HI on Start.
REQ-019 SHALL transition LEN_HI to LEN_LO on a byte transfer.
REQ-020 SHALL transition LEN_LO to WORD_HI on a byte transfer if N != 0, else to DONE.
REQ-021 SHALL transition WORD_HI to WORD_LO on a byte transfer.
REQ-022 SHALL transition WORD_LO to WORD_HI on a byte transfer while words remain, else to DONE.
REQ-023 SHALL drive InReady high only in LEN_HI, LEN_LO, WORD_HI and WORD_LO.
REQ-024 SHALL drive Busy high in those same four states.
REQ-025 SHALL drive Done high only in DONE, and SHALL hold Done until the next Start or reset.
REQ-026 SHALL pulse WrEn for exactly one cycle, registered, on the cycle after each WORD_LO transfer.
REQ-027 SHALL drive WrData = {hi,lo}[W-1:0] during the WrEn cycle.
REQ-028 SHALL start WrAddr at 0 for each load and increment it by 1 after each write.
REQ-029 SHALL wrap WrAddr modulo 2**A when N exceeds 2**A, so later words overwrite earlier ones.
REQ-030 SHALL ignore Start while Busy.
REQ-031 SHALL let the source stall at any byte (InValid low) with no state change and no spurious WrEn.
REQ-032 SHALL set Err when {hi,lo}[15:W] != 0 for any word, SHALL still write the truncated word, and SHALL clear Err on Start.
REQ-033 SHALL keep WrAddr and WrData stable when WrEn is low.

Reset
REQ-034 SHALL, while Reset_n is low at a clock edge, enter IDLE and set InReady=0, WrEn=0, WrAddr=0, WrData=0, Busy=0, Done=0, Err=0.
REQ-035 SHALL abort any load when reset is asserted mid-load, with no WrEn on the cycle after reset.

Structure
REQ-036 SHALL place the loader state enum and the stream-format constants (header length 2, bytes per word 2) in a shared package, loader_pkg.
REQ-037 SHALL be a single module with no sub-module; the InstROM-compatible instruction RAM stays external, written through WrEn, WrAddr and WrData.

Verification
REQ-038 SHALL verify: Start, then bytes 00 02 01 23 00 45 with no stalls -> writes (0,0x123) and (1,0x045), then Done=1 and Err=0.
REQ-039 SHALL verify: Start, then 00 00 -> no WrEn, and Done one cycle after the second byte.
REQ-040 SHALL verify: N=1, word FE 01 -> write (0,0x001) and Err=1; a following Start clears Err.
REQ-041 SHALL verify: N=3 with random InValid gaps -> exactly 3 WrEn pulses at addresses 0,1,2, and Start pulses mid-load are ignored.
REQ-042 SHALL verify: Reset_n low after the first word -> all outputs at reset values next cycle; a restarted load writes from address 0.
REQ-043 SHALL verify: with A=2, N=5 -> fifth write at address 0, and Done=1.
